// File: rtl/trackball_pkg.sv
// -----------------------------------------------------------------------------
// trackball_pkg
// Shared types and helpers for the trackball / joystick-as-mouse converter.
//   phase_t      : 2-bit quadrature phase {a,b}
//   PHASE_SEQ    : phase order for a positive step (00 -> 01 -> 11 -> 10 -> 00)
//   IDX_*        : bit positions of the raw input lines in the synchroniser vector
//   next_phase() : advance a phase one step forward (dir > 0) or backward
//   sat_add()    : signed add clamped to +/- lim
// -----------------------------------------------------------------------------
package trackball_pkg;

    typedef logic [1:0] phase_t;

    localparam phase_t PHASE_SEQ [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    // Positions in the synchronised input vector. Direction lines sit in the
    // low nibble so edge detection can work on [3:0] directly.
    localparam int IDX_UP    = 0;
    localparam int IDX_DOWN  = 1;
    localparam int IDX_LEFT  = 2;
    localparam int IDX_RIGHT = 3;
    localparam int IDX_BTN_R = 4;
    localparam int IDX_BTN_L = 5;

    function automatic phase_t next_phase(input phase_t cur, input int dir);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (PHASE_SEQ[i] == cur) begin
                idx = 2'(i);
            end
        end
        // 2-bit index arithmetic wraps naturally around the 4-entry cycle
        idx = (dir > 0) ? idx + 2'd1 : idx - 2'd1;
        return PHASE_SEQ[idx];
    endfunction

    function automatic int sat_add(input int acc, input int delta, input int lim);
        int sum;
        sum = acc + delta;
        if (sum > lim) begin
            sum = lim;
        end else if (sum < -lim) begin
            sum = -lim;
        end
        return sum;
    endfunction

endpackage

// File: rtl/trackball_mouse_quad_axis.sv
// -----------------------------------------------------------------------------
// quad_axis
// One motion axis: signed saturating step accumulator plus quadrature phase.
//   clk, reset_n   : clock, asynchronous active-low reset
//   inc, dec       : one trackball step in +/- direction this cycle
//   tick           : pacer tick; replays one buffered step if acc != 0
//   emu_step_pos/neg : joystick-mode step request (opposite requests cancel)
//   mode           : 0 = trackball (accumulator path), 1 = joystick emulation
//   clear          : drop buffered motion (phase is kept)
//   ab             : current quadrature phase {a,b}
// -----------------------------------------------------------------------------
module quad_axis
    import trackball_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   inc,
    input  logic   dec,
    input  logic   tick,
    input  logic   emu_step_pos,
    input  logic   emu_step_neg,
    input  logic   mode,
    input  logic   clear,
    output phase_t ab
);

    localparam int ACC_MAX = (1 << (CNT_W - 1)) - 1;

    logic signed [CNT_W-1:0] acc_reg, acc_next;
    phase_t                  ab_reg, ab_next;
    int                      delta_in;
    int                      acc_sign;

    always_comb begin
        acc_next = acc_reg;
        ab_next  = ab_reg;
        delta_in = 0;
        acc_sign = 0;

        if (acc_reg > 0) begin
            acc_sign = 1;
        end else if (acc_reg < 0) begin
            acc_sign = -1;
        end

        if (inc) begin
            delta_in = 1;
        end else if (dec) begin
            delta_in = -1;
        end

        if (clear) begin
            acc_next = '0;
        end else if (mode) begin
            acc_next = '0;
            if (emu_step_pos && !emu_step_neg) begin
                ab_next = next_phase(ab_reg, 1);
            end else if (emu_step_neg && !emu_step_pos) begin
                ab_next = next_phase(ab_reg, -1);
            end
        end else if (tick && acc_sign != 0) begin
            // Incoming step and replayed step are summed before clamping, so an
            // edge arriving on a tick at full scale is not lost.
            ab_next  = next_phase(ab_reg, acc_sign);
            acc_next = CNT_W'(sat_add(int'(acc_reg), delta_in - acc_sign, ACC_MAX));
        end else begin
            acc_next = CNT_W'(sat_add(int'(acc_reg), delta_in, ACC_MAX));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg <= '0;
            ab_reg  <= 2'b00;
        end else begin
            acc_reg <= acc_next;
            ab_reg  <= ab_next;
        end
    end

    assign ab = ab_reg;

endmodule

// File: rtl/trackball_mouse.sv
// -----------------------------------------------------------------------------
// trackball_mouse
// Converts trackball toggle lines or joystick levels into the 6-bit Atari ST
// mouse-port vector {btn_l, btn_r, xa, xb, ya, yb}.
//   clk          : 32 MHz system clock
//   reset_n      : asynchronous active-low reset
//   mode         : 0 = trackball, 1 = joystick-as-mouse (synchronised here)
//   dir_*_n      : raw direction lines (toggle per step, or active-low levels)
//   btn_l_n/r_n  : raw buttons, active-low
//   mouse_out    : registered output vector, buttons active-high
// -----------------------------------------------------------------------------
module trackball_mouse
    import trackball_pkg::*;
#(
    parameter int STEP_DIV = 4096,
    parameter int EMU_DIV  = 524288,
    parameter int CNT_W    = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mode,
    input  logic       dir_up_n,
    input  logic       dir_down_n,
    input  logic       dir_left_n,
    input  logic       dir_right_n,
    input  logic       btn_l_n,
    input  logic       btn_r_n,
    output logic [5:0] mouse_out
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int EW = (EMU_DIV > 1) ? $clog2(EMU_DIV) : 1;

    logic [5:0]    raw_in;
    logic [5:0]    sync1_reg, sync2_reg;
    logic          mode_s1_reg, mode_sync_reg, mode_prev_reg;
    logic [3:0]    hist_reg;
    logic          primed_reg;
    logic [PW-1:0] pace_reg;
    logic [EW-1:0] emu_reg;
    logic [3:0]    dir_edge;
    logic [3:0]    dir_held;
    logic          mode_chg;
    logic          tick;
    logic          emu_wrap;
    phase_t        axis_ab [2];

    assign raw_in = {btn_l_n, btn_r_n, dir_right_n, dir_left_n, dir_down_n, dir_up_n};

    assign mode_chg = mode_sync_reg ^ mode_prev_reg;
    assign tick     = (pace_reg == PW'(STEP_DIV - 1));
    assign emu_wrap = mode_sync_reg && (emu_reg == EW'(EMU_DIV - 1));
    // Until primed, the history only reloads, so reset/mode change cannot
    // produce a phantom step from a stale history value.
    assign dir_edge = primed_reg ? (sync2_reg[3:0] ^ hist_reg) : 4'b0000;
    assign dir_held = ~sync2_reg[3:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg     <= '1;
            sync2_reg     <= '1;
            mode_s1_reg   <= 1'b0;
            mode_sync_reg <= 1'b0;
            mode_prev_reg <= 1'b0;
            hist_reg      <= 4'hF;
            primed_reg    <= 1'b0;
            pace_reg      <= '0;
            emu_reg       <= '0;
        end else begin
            sync1_reg     <= raw_in;
            sync2_reg     <= sync1_reg;
            mode_s1_reg   <= mode;
            mode_sync_reg <= mode_s1_reg;
            mode_prev_reg <= mode_sync_reg;
            hist_reg      <= sync2_reg[3:0];
            primed_reg    <= !mode_chg;
            pace_reg      <= tick ? '0 : pace_reg + PW'(1);
            if (mode_chg || emu_reg == EW'(EMU_DIV - 1)) begin
                emu_reg <= '0;
            end else begin
                emu_reg <= emu_reg + EW'(1);
            end
        end
    end

    // Axis 0 = x (right positive), axis 1 = y (down positive)
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            localparam int POS_LINE = (gi == 0) ? IDX_RIGHT : IDX_DOWN;
            localparam int NEG_LINE = (gi == 0) ? IDX_LEFT  : IDX_UP;

            quad_axis #(
                .CNT_W(CNT_W)
            ) u_axis (
                .clk          (clk),
                .reset_n      (reset_n),
                .inc          (dir_edge[POS_LINE] & ~dir_edge[NEG_LINE]),
                .dec          (dir_edge[NEG_LINE] & ~dir_edge[POS_LINE]),
                .tick         (tick),
                .emu_step_pos (emu_wrap & dir_held[POS_LINE] & ~dir_held[NEG_LINE]),
                .emu_step_neg (emu_wrap & dir_held[NEG_LINE] & ~dir_held[POS_LINE]),
                .mode         (mode_sync_reg),
                .clear        (mode_chg),
                .ab           (axis_ab[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mouse_out <= 6'b000000;
        end else begin
            mouse_out <= {~sync2_reg[IDX_BTN_L], ~sync2_reg[IDX_BTN_R], axis_ab[0], axis_ab[1]};
        end
    end

endmodule

// File: tb/tb_trackball_mouse.sv
// -----------------------------------------------------------------------------
// tb_trackball_mouse
// Scoreboard bench: stimulus pushes expected mouse_out values (optionally with
// the exact cycle or spacing at which they must appear); a negedge monitor pops
// and compares on every change of mouse_out.
// -----------------------------------------------------------------------------
module tb_trackball_mouse;

    typedef struct {
        logic [5:0] val;
        int         at;   // required cycle of appearance, -1 = any
        int         gap;  // required cycles since previous change, 0 = any
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       mode = 1'b0;
    logic       dir_up_n = 1'b1;
    logic       dir_down_n = 1'b1;
    logic       dir_left_n = 1'b1;
    logic       dir_right_n = 1'b1;
    logic       btn_l_n = 1'b1;
    logic       btn_r_n = 1'b1;
    logic [5:0] mouse_out;

    exp_t       exp_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    logic       mon_en = 1'b0;
    logic [5:0] last_out = 6'b000000;
    int         last_chg = 0;
    logic [1:0] pos_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int         xi = 0;
    int         yi = 0;
    int         p;

    trackball_mouse #(
        .STEP_DIV(4),
        .EMU_DIV (8),
        .CNT_W   (6)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mode       (mode),
        .dir_up_n   (dir_up_n),
        .dir_down_n (dir_down_n),
        .dir_left_n (dir_left_n),
        .dir_right_n(dir_right_n),
        .btn_l_n    (btn_l_n),
        .btn_r_n    (btn_r_n),
        .mouse_out  (mouse_out)
    );

    always #5 clk = ~clk;

    // Cycle count since reset release; equals the pacer count modulo STEP_DIV.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic [5:0] mo(input logic bl, input logic br, input int xv, input int yv);
        logic [1:0] xp, yp;
        xp = pos_seq[xv & 3];
        yp = pos_seq[yv & 3];
        return {bl, br, xp, yp};
    endfunction

    task automatic push(input logic [5:0] v, input int at, input int gap);
        exp_t e;
        e.val = v;
        e.at  = at;
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_phase(input int r);
        do begin
            @(posedge clk);
            #1;
        end while ((cyc % 4) != r);
    endtask

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    task automatic wait_drain(input string name, input int bound);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            tick_n(1);
            k++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: %0d expected outputs never appeared, expected 0 pending", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every change of mouse_out must match the head of the queue.
    always @(negedge clk) begin
        if (mon_en && mouse_out !== last_out) begin
            last_out = mouse_out;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_change: got %b at cycle %0d, expected no change", mouse_out, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if (mouse_out !== e.val) begin
                    n_bad++;
                    $display("FAIL out_value: got %b, expected %b", mouse_out, e.val);
                end
                if (e.at >= 0) begin
                    n_cmp++;
                    if (cyc != e.at) begin
                        n_bad++;
                        $display("FAIL out_cycle: %b appeared at cycle %0d, expected %0d", mouse_out, cyc, e.at);
                    end
                end
                if (e.gap > 0) begin
                    n_cmp++;
                    if (cyc - last_chg != e.gap) begin
                        n_bad++;
                        $display("FAIL out_gap: spacing %0d cycles, expected %0d", cyc - last_chg, e.gap);
                    end
                end
            end
            last_chg = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset and idle: no phantom step from priming ----
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        tick_n(1);
        check("idle_c1", mouse_out, 6'b000000);
        tick_n(49);
        check("idle_c50", mouse_out, 6'b000000);
        tick_n(50);
        check("idle_c100", mouse_out, 6'b000000);

        // ---- 4 right toggles in consecutive cycles: 4 paced forward x steps ----
        wait_phase(0);
        p = cyc;
        for (int n = 1; n <= 4; n++) begin
            xi++;
            push(mo(0, 0, xi, yi), p + 1 + 4 * n, 0);
        end
        for (int i = 0; i < 4; i++) begin
            dir_right_n = ~dir_right_n;
            tick_n(1);
        end
        wait_drain("tb_right_burst", 60);

        // ---- 48 left toggles: acc saturates at -31, 12 steps during burst + 31 after ----
        wait_phase(0);
        p = cyc;
        for (int n = 1; n <= 43; n++) begin
            xi--;
            push(mo(0, 0, xi, yi), p + 1 + 4 * n, 0);
        end
        for (int i = 0; i < 48; i++) begin
            dir_left_n = ~dir_left_n;
            tick_n(1);
        end
        wait_drain("tb_left_saturate", 250);
        tick_n(20);
        check("sat_no_extra", mouse_out, mo(0, 0, xi, yi));

        // ---- up and down edges in the same cycle cancel ----
        for (int i = 0; i < 2; i++) begin
            dir_up_n   = ~dir_up_n;
            dir_down_n = ~dir_down_n;
            tick_n(7);
        end
        tick_n(20);
        check("ud_cancel", mouse_out, mo(0, 0, xi, yi));

        // ---- down edge coinciding with a tick while acc_y = +1 ----
        wait_phase(2);
        p = cyc;
        yi++;
        push(mo(0, 0, xi, yi), p + 7, 0);
        yi++;
        push(mo(0, 0, xi, yi), p + 11, 0);
        dir_down_n = ~dir_down_n;
        tick_n(3);
        dir_down_n = ~dir_down_n;
        wait_drain("tb_edge_on_tick", 40);
        tick_n(12);
        check("edge_on_tick_settle", mouse_out, mo(0, 0, xi, yi));

        // ---- joystick emulation ----
        mode = 1'b1;
        tick_n(10);
        for (int n = 1; n <= 4; n++) begin
            xi++;
            push(mo(0, 0, xi, yi), -1, (n == 1) ? 0 : 8);
        end
        dir_right_n = 1'b0;
        tick_n(32);
        dir_right_n = 1'b1;
        wait_drain("jm_right_hold", 60);
        tick_n(10);
        dir_left_n  = 1'b0;
        dir_right_n = 1'b0;
        tick_n(40);
        dir_left_n  = 1'b1;
        dir_right_n = 1'b1;
        tick_n(10);
        check("jm_opposite", mouse_out, mo(0, 0, xi, yi));
        mode = 1'b0;
        tick_n(20);
        check("mode_back", mouse_out, mo(0, 0, xi, yi));

        // ---- buttons: 3-cycle latency ----
        p = cyc;
        btn_l_n = 1'b0;
        push(mo(1, 0, xi, yi), p + 3, 0);
        tick_n(2);
        check("btn_l_lat2", {5'b0, mouse_out[5]}, 6'b000000);
        tick_n(1);
        check("btn_l_lat3", {5'b0, mouse_out[5]}, 6'b000001);
        tick_n(4);
        p = cyc;
        btn_l_n = 1'b1;
        push(mo(0, 0, xi, yi), p + 3, 0);
        tick_n(6);
        p = cyc;
        btn_r_n = 1'b0;
        push(mo(0, 1, xi, yi), p + 3, 0);
        tick_n(6);
        p = cyc;
        btn_r_n = 1'b1;
        push(mo(0, 0, xi, yi), p + 3, 0);
        wait_drain("buttons", 20);

        // ---- reset mid-motion ----
        wait_phase(0);
        p = cyc;
        xi++;
        push(mo(0, 0, xi, yi), p + 5, 0);
        for (int i = 0; i < 6; i++) begin
            dir_right_n = ~dir_right_n;
            tick_n(1);
        end
        #1;
        push(6'b000000, -1, 0);
        reset_n = 1'b0;
        #1;
        check("reset_async", mouse_out, 6'b000000);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        xi = 0;
        yi = 0;
        tick_n(60);
        check("reset_no_steps", mouse_out, 6'b000000);
        wait_drain("reset_flush", 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
